// File: rtl/gcn_arb_pkg.sv
// Shared types and requester indices for the FM_WM result-memory arbiter.
package gcn_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_TRANS = 0;
    localparam int unsigned REQ_COMB  = 1;
    localparam int unsigned REQ_OUT   = 2;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker: first requester after rr_ptr wins.
module arb_rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_ptr) + off) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found                   = 1'b1;
                winner[IDX_W'(idx)]     = 1'b1;
                winner_idx              = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fm_wm_mem_arbiter.sv
// Round-robin arbiter with locked bursts for the single-port FM_WM result memory.
module fm_wm_mem_arbiter
    import gcn_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 48,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    arb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            owner     <= owner_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        owner_next     = owner;
        burst_cnt_next = burst_cnt;
        gnt            = '0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if (|pick_onehot) begin
                        gnt         = pick_onehot;
                        rr_ptr_next = pick_idx;
                        if (lock[pick_idx]) begin
                            state_next     = ARB_LOCKED;
                            owner_next     = pick_idx;
                            burst_cnt_next = CNT_W'(1);
                        end
                    end
                end
                ARB_LOCKED: begin
                    // burst_cnt already includes the entry grant, so release once
                    // the incremented count reaches LOCK_MAX total accesses
                    if (req[owner]) begin
                        gnt[owner]     = 1'b1;
                        burst_cnt_next = burst_cnt + 1'b1;
                        if (!lock[owner] || burst_cnt_next >= LOCK_MAX_C)
                            state_next = ARB_IDLE;
                    end else if (!lock[owner]) begin
                        state_next = ARB_IDLE;
                    end
                end
                default: state_next = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                mem_we    = we[k];
                mem_addr  = addr[k*ADDR_W +: ADDR_W];
                mem_wdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rvalid <= '0;
        else       rvalid <= gnt & ~we;
    end

    assign rdata = mem_rdata;
    assign busy  = (state == ARB_LOCKED);

endmodule

// File: tb/tb_fm_wm_mem_arbiter.sv
// Scoreboard bench for fm_wm_mem_arbiter with a behavioural 1-cycle memory.
module tb_fm_wm_mem_arbiter;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 48;
    localparam int unsigned LOCK_MAX = 4;

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [DATA_W-1:0]  data;
    } sb_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req, lock, we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt, rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_en, mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata = '0;
    logic                      busy;

    logic [ADDR_W-1:0] a_v [NUM_REQ];
    logic [DATA_W-1:0] d_v [NUM_REQ];

    logic [DATA_W-1:0] mem [8] = '{48'hC0DE_0000_0000, 48'hC0DE_0000_1111, 48'hC0DE_0000_2222,
                                   48'hC0DE_0000_3333, 48'hC0DE_0000_4444, 48'hC0DE_0000_5555,
                                   48'hC0DE_0000_6666, 48'hC0DE_0000_7777};
    logic [DATA_W-1:0] exp_mem [8] = '{48'hC0DE_0000_0000, 48'hC0DE_0000_1111, 48'hC0DE_0000_2222,
                                       48'hC0DE_0000_3333, 48'hC0DE_0000_4444, 48'hC0DE_0000_5555,
                                       48'hC0DE_0000_6666, 48'hC0DE_0000_7777};

    sb_t sbq [$];
    int  checks = 0;
    int  errors = 0;

    assign addr  = {a_v[2], a_v[1], a_v[0]};
    assign wdata = {d_v[2], d_v[1], d_v[0]};

    fm_wm_mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic sb_t exp_item(input logic [NUM_REQ-1:0] g, input logic [NUM_REQ-1:0] w);
        sb_t e;
        e.rv   = g & ~w;
        e.data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (e.rv[k]) e.data = exp_mem[a_v[k]];
        return e;
    endfunction

    task automatic drive(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                         input logic [NUM_REQ-1:0] w);
        req  = r;
        lock = l;
        we   = w;
    endtask

    task automatic scoreboard_monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (!reset && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (rvalid !== e.rv) begin
                    errors++;
                    $display("FAIL rvalid: got %b expected %b at %0t", rvalid, e.rv, $time);
                end
                if (e.rv != '0) begin
                    checks++;
                    if (rdata !== e.data) begin
                        errors++;
                        $display("FAIL rdata: got %h expected %h at %0t", rdata, e.data, $time);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        drive('0, '0, '0);
        sbq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive('0, '0, '0);
        #1;
        sbq.push_back(exp_item('0, '0));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(3'b111, 3'b111, 3'b000);
        #3;
        checks++;
        if (gnt !== 3'b000 || mem_en !== 1'b0 || busy !== 1'b0 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b mem_en=%b busy=%b rvalid=%b expected 000/0/0/000",
                     gnt, mem_en, busy, rvalid);
        end
        @(negedge clk);
        reset = 1'b0;
        drive('0, '0, '0);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] exp_a [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
        do_reset();
        a_v[0] = 3'd1; a_v[1] = 3'd2; a_v[2] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(3'b111, 3'b000, 3'b000);
            #1;
            checks++;
            if (gnt !== exp_g[i] || mem_addr !== exp_a[i] || mem_en !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL rr_step%0d: got gnt=%b addr=%0d en=%b we=%b expected gnt=%b addr=%0d en=1 we=0",
                         i, gnt, mem_addr, mem_en, mem_we, exp_g[i], exp_a[i]);
            end
            sbq.push_back(exp_item(exp_g[i], 3'b000));
        end
        idle_cycle();
    endtask

    task automatic test_locked_pair();
        logic [2:0] r_t [5] = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b001};
        logic [2:0] l_t [5] = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        logic [2:0] a_t [5] = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4};
        logic [2:0] exp_g [5] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b001};
        logic       exp_b [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        a_v[0] = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_v[1] = a_t[i];
            drive(r_t[i], l_t[i], 3'b000);
            #1;
            checks++;
            if (gnt !== exp_g[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL lock_pair_step%0d: got gnt=%b busy=%b expected gnt=%b busy=%b",
                         i, gnt, busy, exp_g[i], exp_b[i]);
            end
            sbq.push_back(exp_item(exp_g[i], 3'b000));
        end
        idle_cycle();
    endtask

    task automatic test_lock_max();
        logic [2:0] r_t [6] = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
        logic [2:0] l_t [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        logic       exp_b [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        a_v[0] = 3'd0; a_v[1] = 3'd6; a_v[2] = 3'd7;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(r_t[i], l_t[i], 3'b000);
            #1;
            checks++;
            if (gnt !== exp_g[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL lock_max_step%0d: got gnt=%b busy=%b expected gnt=%b busy=%b",
                         i, gnt, busy, exp_g[i], exp_b[i]);
            end
            sbq.push_back(exp_item(exp_g[i], 3'b000));
        end
        idle_cycle();
    endtask

    task automatic test_write_read();
        do_reset();
        a_v[0] = 3'd5; a_v[1] = 3'd1; a_v[2] = 3'd5;
        d_v[0] = 48'h00AB_CDEF_0123; d_v[1] = 48'hFFFF_FFFF_FFFF; d_v[2] = 48'h1234_5678_9ABC;
        @(negedge clk);
        drive(3'b001, 3'b000, 3'b111);
        #1;
        checks++;
        if (gnt !== 3'b001 || mem_we !== 1'b1 || mem_addr !== 3'd5 || mem_wdata !== 48'h00AB_CDEF_0123) begin
            errors++;
            $display("FAIL write_drive: got gnt=%b we=%b addr=%0d wdata=%h expected 001/1/5/00abcdef0123",
                     gnt, mem_we, mem_addr, mem_wdata);
        end
        sbq.push_back(exp_item(3'b001, 3'b111));
        exp_mem[5] = 48'h00AB_CDEF_0123;
        @(negedge clk);
        drive(3'b100, 3'b000, 3'b000);
        #1;
        checks++;
        if (gnt !== 3'b100 || mem_we !== 1'b0 || mem_addr !== 3'd5) begin
            errors++;
            $display("FAIL read_drive: got gnt=%b we=%b addr=%0d expected 100/0/5", gnt, mem_we, mem_addr);
        end
        sbq.push_back(exp_item(3'b100, 3'b000));
        idle_cycle();
    endtask

    task automatic test_idle_hold();
        logic [2:0] r_t [7] = '{3'b001, 3'b011, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        logic [2:0] l_t [7] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [2:0] exp_g [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
        logic       exp_b [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        a_v[0] = 3'd3; a_v[1] = 3'd4; a_v[2] = 3'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(r_t[i], l_t[i], 3'b000);
            #1;
            checks++;
            if (gnt !== exp_g[i] || busy !== exp_b[i]) begin
                errors++;
                $display("FAIL idle_hold_step%0d: got gnt=%b busy=%b expected gnt=%b busy=%b",
                         i, gnt, busy, exp_g[i], exp_b[i]);
            end
            sbq.push_back(exp_item(exp_g[i], 3'b000));
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        a_v[0] = 3'd2; a_v[1] = 3'd6; a_v[2] = 3'd1;
        @(negedge clk);
        drive(3'b010, 3'b010, 3'b000);
        #1;
        checks++;
        if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL midburst_grant: got gnt=%b expected 010", gnt);
        end
        sbq.push_back(exp_item(3'b010, 3'b000));
        @(negedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midburst_locked: got busy=%b expected 1", busy);
        end
        reset = 1'b1;
        sbq.delete();
        #1;
        checks++;
        if (rvalid !== 3'b000 || busy !== 1'b0 || gnt !== 3'b000 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: got rvalid=%b busy=%b gnt=%b mem_en=%b expected 000/0/000/0",
                     rvalid, busy, gnt, mem_en);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(3'b110, 3'b000, 3'b000);
        #1;
        checks++;
        if (gnt !== 3'b010 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_grant: got gnt=%b busy=%b expected 010/0", gnt, busy);
        end
        sbq.push_back(exp_item(3'b010, 3'b000));
        idle_cycle();
        idle_cycle();
    endtask

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            a_v[k] = '0;
            d_v[k] = '0;
        end
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_round_robin();
        test_locked_pair();
        test_lock_max();
        test_write_read();
        test_idle_hold();
        test_reset_mid_burst();
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
